// File: rtl/uart_pkg.sv
// Shared UART constants, receiver FSM state encoding and frame outcome classification.
// Imported by both the receive and transmit paths.
package uart_pkg;

    localparam int unsigned SIZE_DATA   = 8;
    localparam int unsigned OVER_SAMPLE = 16;
    localparam int unsigned MID_SAMPLE  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        RX_NONE      = 2'd0,
        RX_DONE      = 2'd1,
        RX_OVERRUN   = 2'd2,
        RX_FRAME_ERR = 2'd3
    } rx_outcome_e;

    // A low stop bit is a framing error regardless of FIFO state.
    function automatic rx_outcome_e rx_outcome(input logic stop_bit, input logic fifo_full);
        if (!stop_bit) begin
            return RX_FRAME_ERR;
        end
        return fifo_full ? RX_OVERRUN : RX_DONE;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-to-RX-FIFO interface: character, strobes, status and the FIFO-full back-pressure.
// master = receiver side, slave = FIFO side.
interface uart_receiver_if #(
    parameter int unsigned DATA_W = uart_pkg::SIZE_DATA
);
    logic              i_fifo_full;
    logic [DATA_W-1:0] o_rx_data;
    logic              o_rx_done;
    logic              o_frame_err;
    logic              o_overrun;
    logic              o_busy;

    modport master (
        input  i_fifo_full,
        output o_rx_data,
        output o_rx_done,
        output o_frame_err,
        output o_overrun,
        output o_busy
    );

    modport slave (
        output i_fifo_full,
        input  o_rx_data,
        input  o_rx_done,
        input  o_frame_err,
        input  o_overrun,
        input  o_busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is parameterized
// so idle-high lines do not see a false edge when leaving reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;
endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: 1 start, SIZE_DATA data bits LSB first, 1 stop, no parity.
// Delivers each character to the RX FIFO with a one-cycle strobe plus framing/overrun pulses.
module uart_receiver #(
    parameter int unsigned SIZE_DATA   = uart_pkg::SIZE_DATA,
    parameter int unsigned OVER_SAMPLE = uart_pkg::OVER_SAMPLE,
    parameter int unsigned MID_SAMPLE  = uart_pkg::MID_SAMPLE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stick,
    input  logic             i_rx_serial,
    uart_receiver_if.master  rx_if
);
    import uart_pkg::*;

    localparam int unsigned TICK_W = $clog2(OVER_SAMPLE);
    localparam int unsigned BIT_W  = $clog2(SIZE_DATA + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(MID_SAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVER_SAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SIZE_DATA - 1);

    logic rx_s;

    rx_state_e             state_q,     state_d;
    logic [TICK_W-1:0]     tick_cnt_q,  tick_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [SIZE_DATA-1:0]  shift_q,     shift_d;
    logic [SIZE_DATA-1:0]  rx_data_q,   rx_data_d;
    logic                  rx_done_q,   rx_done_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q,   overrun_d;
    logic                  busy_q,      busy_d;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx_serial),
        .o_q   (rx_s)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, counters and outcome; everything holds unless an oversample tick arrives.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (i_stick) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        tick_cnt_d = '0;
                        state_d    = START;
                    end
                end
                START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            bit_cnt_d = '0;
                            state_d   = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[SIZE_DATA-1:1]};
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit gives half a bit of slack to catch the next start edge.
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        unique case (rx_outcome(rx_s, rx_if.i_fifo_full))
                            RX_DONE: begin
                                rx_data_d = shift_q;
                                rx_done_d = 1'b1;
                            end
                            RX_OVERRUN: begin
                                rx_data_d = shift_q;
                                overrun_d = 1'b1;
                            end
                            RX_FRAME_ERR: begin
                                frame_err_d = 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign rx_if.o_rx_data   = rx_data_q;
    assign rx_if.o_rx_done   = rx_done_q;
    assign rx_if.o_frame_err = frame_err_q;
    assign rx_if.o_overrun   = overrun_q;
    assign rx_if.o_busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed and random frames driven at bit level, outcomes predicted
// per frame from the line contents and FIFO state, and checked every cycle by a compare process.
module tb_uart_receiver;
    import uart_pkg::*;

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic stick     = 1'b0;
    logic rx_serial = 1'b1;
    int   div       = 0;

    uart_receiver_if rx_if ();

    uart_receiver dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_stick     (stick),
        .i_rx_serial (rx_serial),
        .rx_if       (rx_if)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clock in four.
    always @(posedge clk) begin
        div   <= (div == 3) ? 0 : div + 1;
        stick <= (div == 3);
    end

    typedef enum int {EV_DONE = 0, EV_OVR = 1, EV_FERR = 2} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         n_chk      = 0;
    int         n_pass     = 0;
    int         n_done     = 0;
    int         n_ovr      = 0;
    int         n_ferr     = 0;
    logic [7:0] model_data = 8'h00;
    logic       in_stop    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Compare process: pulses must match the oldest predicted frame outcome; data held in between.
    always @(negedge clk) begin : compare
        int       np;
        ev_kind_e k;
        ev_t      e;
        if (rst) begin
            model_data = 8'h00;
        end else begin
            np = int'(rx_if.o_rx_done) + int'(rx_if.o_overrun) + int'(rx_if.o_frame_err);
            if (np > 1) chk("one_pulse_at_a_time", np, 1);
            if (np == 1) begin
                k = rx_if.o_rx_done ? EV_DONE : (rx_if.o_overrun ? EV_OVR : EV_FERR);
                if (k == EV_DONE) n_done++;
                if (k == EV_OVR)  n_ovr++;
                if (k == EV_FERR) n_ferr++;
                chk("pulse_during_stop_bit", int'(in_stop), 1);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pulse: got kind %0d, expected no pulse (t=%0t)", int'(k), $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", int'(k), int'(e.kind));
                    if (e.kind != EV_FERR) model_data = e.data;
                end
            end
            chk("rx_data", int'(rx_if.o_rx_data), int'(model_data));
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!stick) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic full);
        ev_t e;
        chk("busy_low_before_start", int'(rx_if.o_busy), 0);
        rx_if.i_fifo_full = full;
        rx_serial = 1'b0;
        wait_ticks(16);
        for (int k = 0; k < 8; k++) begin
            rx_serial = d[k];
            wait_ticks(8);
            if (k == 2) chk("busy_high_mid_frame", int'(rx_if.o_busy), 1);
            wait_ticks(8);
        end
        e.kind = !stop ? EV_FERR : (full ? EV_OVR : EV_DONE);
        e.data = d;
        exp_q.push_back(e);
        rx_serial = stop;
        in_stop   = 1'b1;
        wait_ticks(16);
        in_stop   = 1'b0;
        rx_serial = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_data"},   int'(rx_if.o_rx_data),   0);
        chk({tag, "_rx_done"},   int'(rx_if.o_rx_done),   0);
        chk({tag, "_frame_err"}, int'(rx_if.o_frame_err), 0);
        chk({tag, "_overrun"},   int'(rx_if.o_overrun),   0);
        chk({tag, "_busy"},      int'(rx_if.o_busy),      0);
    endtask

    initial begin : driver
        int         d0, o0, f0;
        logic [7:0] rd;
        logic       rstop, rfull;
        bit         prev_ferr;

        rx_if.i_fifo_full = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_reset_values("reset");
        @(negedge clk) rst = 1'b0;
        wait_ticks(4);

        // Basic frame.
        d0 = n_done; o0 = n_ovr; f0 = n_ferr;
        send_frame(8'h55, 1'b1, 1'b0);
        wait_ticks(4);
        chk("basic_done_count", n_done - d0, 1);
        chk("basic_rx_data", int'(rx_if.o_rx_data), 8'h55);
        chk("basic_no_errors", (n_ovr - o0) + (n_ferr - f0), 0);

        // Back-to-back frames, zero idle time.
        d0 = n_done;
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        wait_ticks(4);
        chk("b2b_done_count", n_done - d0, 2);
        chk("b2b_rx_data", int'(rx_if.o_rx_data), 8'h0F);

        // Start glitch.
        d0 = n_done; o0 = n_ovr; f0 = n_ferr;
        rx_serial = 1'b0;
        wait_ticks(2);
        chk("glitch_busy_in_start", int'(rx_if.o_busy), 1);
        wait_ticks(2);
        rx_serial = 1'b1;
        wait_ticks(6);
        chk("glitch_busy_low", int'(rx_if.o_busy), 0);
        wait_ticks(10);
        chk("glitch_no_pulses", (n_done - d0) + (n_ovr - o0) + (n_ferr - f0), 0);

        // Framing error.
        d0 = n_done; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(10);
        chk("ferr_count", n_ferr - f0, 1);
        chk("ferr_no_done", n_done - d0, 0);
        chk("ferr_rx_data_kept", int'(rx_if.o_rx_data), 8'h0F);

        // Overrun.
        d0 = n_done; o0 = n_ovr;
        send_frame(8'h77, 1'b1, 1'b1);
        rx_if.i_fifo_full = 1'b0;
        wait_ticks(4);
        chk("ovr_count", n_ovr - o0, 1);
        chk("ovr_no_done", n_done - d0, 0);
        chk("ovr_rx_data", int'(rx_if.o_rx_data), 8'h77);

        // Reset during data bit 4 of 0xFF.
        rx_serial = 1'b0;
        wait_ticks(16);
        rx_serial = 1'b1;
        wait_ticks(4 * 16 + 8);
        @(negedge clk);
        rst       = 1'b1;
        rx_serial = 1'b1;
        #1 check_reset_values("midframe_reset");
        @(negedge clk) rst = 1'b0;
        wait_ticks(20);
        chk("after_reset_busy", int'(rx_if.o_busy), 0);
        d0 = n_done;
        send_frame(8'h12, 1'b1, 1'b0);
        wait_ticks(4);
        chk("after_reset_done_count", n_done - d0, 1);
        chk("after_reset_rx_data", int'(rx_if.o_rx_data), 8'h12);

        // Random frames: data, FIFO state, stop-bit corruption and idle gaps.
        prev_ferr = 1'b0;
        for (int i = 0; i < 36; i++) begin
            rd    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 7) != 0);
            rfull = ($urandom_range(0, 3) == 0);
            send_frame(rd, rstop, rfull);
            prev_ferr = !rstop;
            if (prev_ferr) wait_ticks(8 + $urandom_range(0, 8));
            else if ($urandom_range(0, 1) == 1) wait_ticks($urandom_range(1, 12));
        end
        rx_if.i_fifo_full = 1'b0;
        wait_ticks(24);
        chk("all_outcomes_seen", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

- Serial-to-parallel UART receiver; mirror of the transmit path.
- Samples the asynchronous `i_rx_serial` line using the shared baud generator's oversample tick (`i_stick`).
- Frame format: 1 start bit, `SIZE_DATA` data bits LSB-first, 1 stop bit, no parity.
- Deframes each character and presents it to the RX FIFO with a one-cycle write strobe, flagging framing errors and FIFO overruns.

## Interface
- `SIZE_DATA`, 8, data bits per frame.
- `OVER_SAMPLE`, 16, `i_stick` pulses per bit period.
- `MID_SAMPLE`, 8, tick index within a bit at which the line is sampled; must be less than `OVER_SAMPLE`.

Ports:
- `i_clk`  in  1  system clock (50 MHz nominal).
- `i_rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `i_stick`  in  1  one-clock oversample tick from the baud generator (9600 × 16).
- `i_rx_serial`  in  1  asynchronous serial line, idle high.
- `i_fifo_full`  in  1  RX FIFO full.
- `o_rx_data`  out  `SIZE_DATA`  last received character; holds until the next good frame.
- `o_rx_done`  out  1  one-clock FIFO write strobe for a good frame.
- `o_frame_err`  out  1  one-clock pulse: stop bit sampled low.
- `o_overrun`  out  1  one-clock pulse: good frame arrived while the FIFO was full.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- **Input synchronizer:** `i_rx_serial` passes through a 2-flop synchronizer, which resets to 1. Every line decision uses the synchronized value `rx_s`.
- **Counters:**
  - `tick_cnt`: width `$clog2(OVER_SAMPLE)`, advances only on `i_stick`.
  - `bit_cnt`: width `$clog2(SIZE_DATA+1)`.
  - Shift register: `SIZE_DATA` bits; receives data right-shift, MSB-in, so the LSB arrives first.
- **FSM:** states IDLE, START, DATA, STOP.
  - **IDLE:** on `i_stick` with `rx_s==0`, clear `tick_cnt` and go to START.
  - **START:** on the `i_stick` where `tick_cnt==MID_SAMPLE-1`:
    - If `rx_s==0`, clear `tick_cnt` and `bit_cnt`, then go to DATA.
    - Otherwise treat it as a glitch: return to IDLE with no output.
  - **DATA:** on the `i_stick` where `tick_cnt==OVER_SAMPLE-1`:
    - Shift in `rx_s`, clear `tick_cnt`, increment `bit_cnt`.
    - When `bit_cnt` reaches `SIZE_DATA-1` on that shift, go to STOP.
  - **STOP:** on the `i_stick` where `tick_cnt==OVER_SAMPLE-1`, sample `rx_s`, then return to IDLE. IDLE is re-entered at mid stop bit, which allows resynchronization on the next start edge.
- **Outcome of the stop-bit sample (one clock):**
  - `rx_s==1` and `!i_fifo_full`: load `o_rx_data` from the shift register and pulse `o_rx_done`.
  - `rx_s==1` and `i_fifo_full`: load `o_rx_data` and pulse `o_overrun`; no `o_rx_done`.
  - `rx_s==0`: pulse `o_frame_err`; `o_rx_data` and `o_rx_done` are untouched.
- **Outside `i_stick`:** no state or counter changes when `i_stick` is low.

## Timing
- **Reset values:**
  - State IDLE; counters and shift register 0.
  - `o_rx_data=0`, `o_rx_done=0`, `o_frame_err=0`, `o_overrun=0`, `o_busy=0`.
  - Synchronizer flops at 1.
- **Reset mid-frame:** asynchronous return to the reset values. The partial character is discarded and no pulses are produced.
- **Input latency:** 2 clocks through the synchronizer, plus up to 1 tick of start-detect jitter.
- **Sample points:** start bit is checked at tick 8 after detection. Data bit k is sampled 16·(k+1) ticks after the start check, and the stop bit 16·(SIZE_DATA+1) ticks after it.
- **Output registration:** `o_rx_done`, `o_frame_err` and `o_overrun` are registered. Each asserts on the clock following the `i_stick` on which the stop bit is sampled, and is high for exactly one clock. At most one of the three is high in any cycle.
- **`o_rx_data` validity:** valid in the same cycle as `o_rx_done`, and stable until the next good frame.
- **Back-to-back frames:** a start edge seen on the first `i_stick` after returning to IDLE is accepted. Zero idle time between frames is supported.

## Structure
- Package `uart_pkg`: FSM state enum `rx_state_e` (IDLE, START, DATA, STOP); default constants `SIZE_DATA`, `OVER_SAMPLE`, `MID_SAMPLE`. The transmitter shares the same constants.
- Sub-module `sync_2ff`: parameterized reset value, instantiated once for `i_rx_serial`.
- The FSM, counters and shift register live in `uart_receiver`.

## Test plan
- **Basic frame:** reset, then drive a frame carrying 0x55 with `baud_generator` `BAUDRATE_VALUE=325` → one `o_rx_done` pulse, `o_rx_data=0x55`, no error pulses.
- **Back-to-back frames:** frames 0xA3 then 0x0F with no idle gap → two `o_rx_done` pulses in order, with `o_rx_data` 0xA3 then 0x0F.
- **Start glitch:** line low for 4 ticks, then high → FSM returns to IDLE, no pulses, `o_busy` low within 9 ticks.
- **Framing error:** frame 0x3C with the stop bit driven 0 → one `o_frame_err` pulse, no `o_rx_done`, `o_rx_data` keeps its previous value.
- **Overrun:** `i_fifo_full=1` during frame 0x77 → one `o_overrun` pulse, `o_rx_data=0x77`, no `o_rx_done`.
- **Reset mid-frame:** assert `i_rst` at data bit 4 of 0xFF → all outputs at reset values; a following 0x12 frame is received correctly.
